// File: rtl/rv32i_control.sv
// Multicycle RV32I control FSM: fetch, decode, execute sequencing
// for LUI, AUIPC, branches, OP-IMM, LW and SW.
module rv32i_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_mem_data_out,
    output logic       pcmux_sel,
    output logic       marmux_sel,
    output logic       alumux1_sel,
    output logic       cmpmux_sel,
    output logic [1:0] alumux2_sel,
    output logic [1:0] regfilemux_sel,
    output logic [2:0] aluop,
    output logic [2:0] cmpop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        S_LUI, S_AUIPC, S_BR, S_IMM,
        CALC_LD, LD1, LD2,
        CALC_ST, ST1, ST2, SKIP
    } state_t;

    state_t state, next_state;

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH1;
        else     state <= next_state;
    end

    always_comb begin
        load_pc           = 1'b0;
        load_ir           = 1'b0;
        load_regfile      = 1'b0;
        load_mar          = 1'b0;
        load_mdr          = 1'b0;
        load_mem_data_out = 1'b0;
        pcmux_sel         = 1'b0;
        marmux_sel        = 1'b0;
        alumux1_sel       = 1'b0;
        cmpmux_sel        = 1'b0;
        alumux2_sel       = 2'd0;
        regfilemux_sel    = 2'd0;
        aluop             = 3'b000;
        cmpop             = 3'b000;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_byte_enable   = 4'b0000;
        next_state        = state;
        // Reset gates every output so in-flight strobes drop immediately
        if (!rst) begin
            case (state)
                FETCH1: begin
                    load_mar   = 1'b1;
                    next_state = FETCH2;
                end
                FETCH2: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                    if (mem_resp) next_state = FETCH3;
                end
                FETCH3: begin
                    load_ir    = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    case (opcode)
                        OP_LUI:   next_state = S_LUI;
                        OP_AUIPC: next_state = S_AUIPC;
                        OP_BR:
                            next_state = (funct3[2:1] == 2'b01) ? SKIP : S_BR;
                        OP_IMM:   next_state = S_IMM;
                        OP_LOAD:
                            next_state = (funct3 == 3'b010) ? CALC_LD : SKIP;
                        OP_STORE:
                            next_state = (funct3 == 3'b010) ? CALC_ST : SKIP;
                        default:  next_state = SKIP;
                    endcase
                end
                S_LUI: begin
                    regfilemux_sel = 2'd2;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    next_state     = FETCH1;
                end
                S_AUIPC: begin
                    alumux1_sel  = 1'b1;
                    alumux2_sel  = 2'd1;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    next_state   = FETCH1;
                end
                S_BR: begin
                    cmpop       = funct3;
                    alumux1_sel = 1'b1;
                    alumux2_sel = 2'd2;
                    pcmux_sel   = br_en;
                    load_pc     = 1'b1;
                    next_state  = FETCH1;
                end
                S_IMM: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    next_state   = FETCH1;
                    case (funct3)
                        3'b010: begin
                            cmpmux_sel     = 1'b1;
                            cmpop          = 3'b100;
                            regfilemux_sel = 2'd1;
                        end
                        3'b011: begin
                            cmpmux_sel     = 1'b1;
                            cmpop          = 3'b110;
                            regfilemux_sel = 2'd1;
                        end
                        3'b101:  aluop = funct7[5] ? 3'b010 : 3'b101;
                        default: aluop = funct3;
                    endcase
                end
                CALC_LD: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    next_state = LD1;
                end
                LD1: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                    if (mem_resp) next_state = LD2;
                end
                LD2: begin
                    regfilemux_sel = 2'd3;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    next_state     = FETCH1;
                end
                CALC_ST: begin
                    alumux2_sel       = 2'd3;
                    marmux_sel        = 1'b1;
                    load_mar          = 1'b1;
                    load_mem_data_out = 1'b1;
                    next_state        = ST1;
                end
                ST1: begin
                    mem_write       = 1'b1;
                    mem_byte_enable = 4'b1111;
                    if (mem_resp) next_state = ST2;
                end
                ST2: begin
                    load_pc    = 1'b1;
                    next_state = FETCH1;
                end
                SKIP: begin
                    load_pc    = 1'b1;
                    next_state = FETCH1;
                end
                default: next_state = FETCH1;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_control.sv
// Bench for rv32i_control: per-instruction cycle schedules are built
// from the instruction class and memory latency, then replayed.
module tb_rv32i_control;

    typedef struct packed {
        logic       load_pc;
        logic       load_ir;
        logic       load_regfile;
        logic       load_mar;
        logic       load_mdr;
        logic       load_mem_data_out;
        logic       pcmux_sel;
        logic       marmux_sel;
        logic       alumux1_sel;
        logic       cmpmux_sel;
        logic [1:0] alumux2_sel;
        logic [1:0] regfilemux_sel;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mem_byte_enable;
    } ctl_t;

    typedef struct {
        ctl_t       exp;
        logic       rst;
        logic       resp;
        logic       wt;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       be;
    } ent_t;

    typedef enum { K_LUI, K_AUIPC, K_BR, K_IMM, K_LW, K_SW, K_SKIP } kind_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       br_en = 1'b0;
    logic       mem_resp = 1'b0;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr;
    logic       load_mem_data_out, pcmux_sel, marmux_sel;
    logic       alumux1_sel, cmpmux_sel, mem_read, mem_write;
    logic [1:0] alumux2_sel, regfilemux_sel;
    logic [2:0] aluop, cmpop;
    logic [3:0] mem_byte_enable;
    ctl_t       act;

    int   vecs = 0;
    int   miscmp = 0;
    ent_t q[$];
    logic [6:0] m_op;
    logic [2:0] m_f3;
    logic [6:0] m_f7;
    logic       m_be;

    rv32i_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .br_en(br_en), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mar(load_mar),
        .load_mdr(load_mdr), .load_mem_data_out(load_mem_data_out),
        .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel),
        .alumux1_sel(alumux1_sel), .cmpmux_sel(cmpmux_sel),
        .alumux2_sel(alumux2_sel), .regfilemux_sel(regfilemux_sel),
        .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
    );

    assign act = {load_pc, load_ir, load_regfile, load_mar, load_mdr,
                  load_mem_data_out, pcmux_sel, marmux_sel, alumux1_sel,
                  cmpmux_sel, alumux2_sel, regfilemux_sel, aluop, cmpop,
                  mem_read, mem_write, mem_byte_enable};

    always #5 clk = ~clk;

    function automatic kind_t classify(input logic [6:0] op,
                                       input logic [2:0] f3);
        case (op)
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_SKIP : K_BR;
            7'h13: return K_IMM;
            7'h03: return (f3 == 3'd2) ? K_LW : K_SKIP;
            7'h23: return (f3 == 3'd2) ? K_SW : K_SKIP;
            default: return K_SKIP;
        endcase
    endfunction

    task automatic push(input ctl_t c, input logic r,
                        input logic resp, input logic wt);
        ent_t e;
        e.exp = c; e.rst = r; e.resp = resp; e.wt = wt;
        e.op = m_op; e.f3 = m_f3; e.f7 = m_f7; e.be = m_be;
        q.push_back(e);
    endtask

    task automatic push_reset(input int n);
        for (int i = 0; i < n; i++) push('0, 1'b1, 1'b0, 1'b1);
    endtask

    // abort >= 0: rst lands on LD1 cycle number abort (0-based)
    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic be,
                               input int fw, input int mw,
                               input int abort);
        ctl_t c;
        kind_t k;
        m_op = op; m_f3 = f3; m_f7 = f7; m_be = be;
        k = classify(op, f3);
        c = '0; c.load_mar = 1; push(c, 0, 0, 0);
        for (int i = 0; i <= fw; i++) begin
            c = '0; c.mem_read = 1; c.load_mdr = 1;
            push(c, 0, i == fw, 1);
        end
        c = '0; c.load_ir = 1; push(c, 0, 0, 0);
        c = '0; push(c, 0, 0, 0);
        c = '0;
        case (k)
            K_LUI: begin
                c.regfilemux_sel = 2; c.load_regfile = 1; c.load_pc = 1;
                push(c, 0, 0, 0);
            end
            K_AUIPC: begin
                c.alumux1_sel = 1; c.alumux2_sel = 1;
                c.load_regfile = 1; c.load_pc = 1;
                push(c, 0, 0, 0);
            end
            K_BR: begin
                c.cmpop = f3; c.alumux1_sel = 1; c.alumux2_sel = 2;
                c.pcmux_sel = be; c.load_pc = 1;
                push(c, 0, 0, 0);
            end
            K_IMM: begin
                c.load_regfile = 1; c.load_pc = 1;
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    c.cmpmux_sel = 1; c.regfilemux_sel = 1;
                    c.cmpop = (f3 == 3'd2) ? 3'b100 : 3'b110;
                end else if (f3 == 3'd5) begin
                    c.aluop = f7[5] ? 3'b010 : 3'b101;
                end else begin
                    c.aluop = f3;
                end
                push(c, 0, 0, 0);
            end
            K_LW: begin
                c.marmux_sel = 1; c.load_mar = 1; push(c, 0, 0, 0);
                if (abort >= 0) begin
                    for (int i = 0; i < abort; i++) begin
                        c = '0; c.mem_read = 1; c.load_mdr = 1;
                        push(c, 0, 0, 1);
                    end
                    push_reset(1);
                end else begin
                    for (int i = 0; i <= mw; i++) begin
                        c = '0; c.mem_read = 1; c.load_mdr = 1;
                        push(c, 0, i == mw, 1);
                    end
                    c = '0; c.regfilemux_sel = 3;
                    c.load_regfile = 1; c.load_pc = 1;
                    push(c, 0, 0, 0);
                end
            end
            K_SW: begin
                c.alumux2_sel = 3; c.marmux_sel = 1;
                c.load_mar = 1; c.load_mem_data_out = 1;
                push(c, 0, 0, 0);
                for (int i = 0; i <= mw; i++) begin
                    c = '0; c.mem_write = 1; c.mem_byte_enable = 4'hf;
                    push(c, 0, i == mw, 1);
                end
                c = '0; c.load_pc = 1; push(c, 0, 0, 0);
            end
            default: begin
                c.load_pc = 1; push(c, 0, 0, 0);
            end
        endcase
    endtask

    task automatic test_reset();
        ent_t e;
        int n = 0;
        m_op = 7'h13; m_f3 = 0; m_f7 = 0; m_be = 1;
        push_reset(2);
        model_instr(7'h37, 3'd0, 7'd0, 1'b0, 0, 0, -1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; opcode = e.op; funct3 = e.f3;
            funct7 = e.f7; br_en = e.be;
            mem_resp = e.wt ? e.resp : ($urandom_range(3) == 0);
            #1;
            vecs++;
            if (act !== e.exp) begin
                miscmp++;
                $display("FAIL reset[%0d]: got %h want %h", n, act, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_imm();
        ent_t e;
        int n = 0;
        model_instr(7'h13, 3'd0, 7'h00, 1'b0, 0, 0, -1);
        model_instr(7'h13, 3'd3, 7'h00, 1'b1, 1, 0, -1);
        model_instr(7'h13, 3'd5, 7'h20, 1'b0, 0, 0, -1);
        model_instr(7'h13, 3'd5, 7'h00, 1'b0, 2, 0, -1);
        model_instr(7'h13, 3'd2, 7'h7f, 1'b1, 0, 0, -1);
        model_instr(7'h17, 3'd7, 7'h00, 1'b0, 0, 0, -1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; opcode = e.op; funct3 = e.f3;
            funct7 = e.f7; br_en = e.be;
            mem_resp = e.wt ? e.resp : ($urandom_range(3) == 0);
            #1;
            vecs++;
            if (act !== e.exp) begin
                miscmp++;
                $display("FAIL imm[%0d]: got %h want %h", n, act, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        ent_t e;
        int n = 0;
        model_instr(7'h63, 3'd1, 7'h00, 1'b1, 0, 0, -1);
        model_instr(7'h63, 3'd1, 7'h00, 1'b0, 0, 0, -1);
        model_instr(7'h63, 3'd7, 7'h00, 1'b1, 0, 0, -1);
        model_instr(7'h63, 3'd3, 7'h00, 1'b1, 0, 0, -1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; opcode = e.op; funct3 = e.f3;
            funct7 = e.f7; br_en = e.be;
            mem_resp = e.wt ? e.resp : ($urandom_range(3) == 0);
            #1;
            vecs++;
            if (act !== e.exp) begin
                miscmp++;
                $display("FAIL branch[%0d]: got %h want %h", n, act, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_store();
        ent_t e;
        int n = 0;
        int wr = 0;
        model_instr(7'h23, 3'd2, 7'h00, 1'b0, 0, 3, -1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; opcode = e.op; funct3 = e.f3;
            funct7 = e.f7; br_en = e.be;
            mem_resp = e.wt ? e.resp : ($urandom_range(3) == 0);
            #1;
            vecs++;
            if (act.mem_write === 1'b1) wr++;
            if (act !== e.exp) begin
                miscmp++;
                $display("FAIL store[%0d]: got %h want %h", n, act, e.exp);
            end
            n++;
        end
        vecs++;
        if (wr !== 4) begin
            miscmp++;
            $display("FAIL store_write_cycles: got %0d want 4", wr);
        end
    endtask

    task automatic test_skip_and_abort();
        ent_t e;
        int n = 0;
        model_instr(7'h6f, 3'd0, 7'h00, 1'b1, 0, 0, -1);
        model_instr(7'h03, 3'd2, 7'h00, 1'b0, 0, 0, 1);
        model_instr(7'h03, 3'd2, 7'h00, 1'b0, 0, 1, -1);
        model_instr(7'h03, 3'd0, 7'h00, 1'b0, 0, 0, -1);
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; opcode = e.op; funct3 = e.f3;
            funct7 = e.f7; br_en = e.be;
            mem_resp = e.wt ? e.resp : ($urandom_range(3) == 0);
            #1;
            vecs++;
            if (act !== e.exp) begin
                miscmp++;
                $display("FAIL skip_abort[%0d]: got %h want %h",
                         n, act, e.exp);
            end
            n++;
        end
    endtask

    task automatic test_random();
        ent_t e;
        int n = 0;
        logic [6:0] ops [9];
        logic [6:0] op;
        ops = '{7'h37, 7'h17, 7'h63, 7'h13, 7'h03, 7'h23,
                7'h6f, 7'h67, 7'h33};
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(9) == 9) ? 7'($urandom)
                                          : ops[$urandom_range(8)];
            model_instr(op, 3'($urandom), 7'($urandom), 1'($urandom),
                        $urandom_range(3), $urandom_range(3), -1);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rst; opcode = e.op; funct3 = e.f3;
            funct7 = e.f7; br_en = e.be;
            mem_resp = e.wt ? e.resp : ($urandom_range(3) == 0);
            #1;
            vecs++;
            if (act !== e.exp) begin
                miscmp++;
                $display("FAIL random[%0d]: got %h want %h op=%h f3=%0d",
                         n, act, e.exp, e.op, e.f3);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_branch();
        test_store();
        test_skip_and_abort();
        test_random();
        @(negedge clk);
        mem_resp = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/rv32i_control.md
# rv32i_control

Moore-style control FSM that sequences the RV32I multicycle datapath through fetch, decode and execute. It drives every load enable, mux select and ALU/compare opcode of the datapath, and runs the memory read/write handshake. It decodes opcode, funct3, funct7 and br_en from the datapath. Supported subset: LUI, AUIPC, conditional branches, OP-IMM, LW, SW. Every other encoding is retired as a no-op that advances the PC.

## Interface
Parameters: none.

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  7  IR opcode field
- funct3  in  3  IR funct3
- funct7  in  7  IR funct7
- br_en  in  1  comparator result
- mem_resp  in  1  memory completion, 1-cycle pulse
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_mem_data_out  out  1 each  datapath register enables
- pcmux_sel  out  1  0 = pc+4, 1 = alu_out
- marmux_sel  out  1  0 = pc, 1 = alu_out
- alumux1_sel  out  1  0 = rs1, 1 = pc
- cmpmux_sel  out  1  0 = rs2, 1 = i_imm
- alumux2_sel  out  2  0 = i_imm, 1 = u_imm, 2 = b_imm, 3 = s_imm
- regfilemux_sel  out  2  0 = alu_out, 1 = {31'b0, br_en}, 2 = u_imm, 3 = mdr
- aluop  out  3  add 000, sll 001, sra 010, sub 011, xor 100, srl 101, or 110, and 111
- cmpop  out  3  branch funct3 encoding: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111
- mem_read, mem_write  out  1 each  memory strobes
- mem_byte_enable  out  4  write byte mask

## Operation

**Outputs and defaults**
- Outputs are a combinational decode of the state, plus the IR fields and br_en where noted.
- Default for every output is 0; this makes aluop = add and cmpop = beq.
- While rst = 1, all outputs are forced to default and the next state is FETCH1.

**States** (4-bit register). Each entry lists only non-default outputs, then the transition.
- FETCH1: load_mar. → FETCH2.
- FETCH2: mem_read, load_mdr. Stays in FETCH2 until mem_resp; on mem_resp → FETCH3.
- FETCH3: load_ir. → DECODE.
- DECODE: no outputs. Dispatch on opcode:
  - 0110111 → LUI
  - 0010111 → AUIPC
  - 1100011 → BR, unless funct3 is 010 or 011 (then SKIP)
  - 0010011 → IMM
  - 0000011 with funct3 010 → CALC_LD
  - 0100011 with funct3 010 → CALC_ST
  - anything else (JAL, JALR, OP, other widths, illegal) → SKIP
- LUI: regfilemux 2, load_regfile, load_pc. → FETCH1.
- AUIPC: alumux1 1, alumux2 1, load_regfile, load_pc. → FETCH1.
- BR: cmpop = funct3, alumux1 1, alumux2 2, pcmux_sel = br_en, load_pc. → FETCH1.
- IMM: load_regfile, load_pc. Per funct3:
  - 010: cmpmux 1, cmpop 100, regfilemux 1.
  - 011: cmpmux 1, cmpop 110, regfilemux 1.
  - 101: aluop 010 if funct7[5] = 1, otherwise 101.
  - all other funct3: aluop = funct3.
  - → FETCH1.
- CALC_LD: marmux 1, load_mar (alumux2 0, aluop add). → LD1.
- LD1: mem_read, load_mdr. Stays in LD1 until mem_resp; on mem_resp → LD2.
- LD2: regfilemux 3, load_regfile, load_pc. → FETCH1.
- CALC_ST: alumux2 3, marmux 1, load_mar, load_mem_data_out. → ST1.
- ST1: mem_write, mem_byte_enable 1111. Stays in ST1 until mem_resp; on mem_resp → ST2.
- ST2: load_pc. → FETCH1.
- SKIP: load_pc. → FETCH1.

**Boundary conditions**
- mem_resp in any state other than FETCH2, LD1 or ST1 is ignored.
- mem_read and mem_write are never asserted together.
- mem_read / mem_write stay high continuously until the cycle mem_resp is sampled, inclusive.
- rst during FETCH2, LD1 or ST1: strobes drop in that same cycle; FETCH1 follows the edge; no register load occurs.

## Timing
- Every state lasts 1 cycle except FETCH2, LD1 and ST1, which last until mem_resp.
- With a 1-cycle mem_resp:
  - LUI, AUIPC, BR, IMM and SKIP take 5 cycles.
  - LW and SW take 7 cycles.
- Each extra memory wait cycle adds 1 cycle.
- After rst deasserts, the first cycle is FETCH1 with load_mar = 1 and marmux 0.
- load_pc is asserted exactly once per instruction, in its final state.

## Test plan
- Reset: hold rst high 2 cycles → all outputs 0. Release → load_mar = 1, then mem_read = 1 the next cycle.
- ADDI (0x00500093), mem_resp in the first FETCH2 cycle → cycle 5 asserts load_regfile, load_pc, aluop 000, alumux2 0, regfilemux 0. Cycle 6 is FETCH1.
- SLTIU (funct3 011) → cmpop 110, cmpmux 1, regfilemux 1. SRAI with funct7 0100000 → aluop 010. SRLI with funct7 0 → aluop 101.
- BNE (funct3 001) → with br_en = 1: cmpop 001, alumux1 1, alumux2 2, pcmux_sel 1. Repeat with br_en = 0 → pcmux_sel 0.
- SW with mem_resp 3 cycles late → mem_write and mem_byte_enable 1111 held 4 cycles. CALC_ST shows alumux2 3 and marmux 1. ST2 shows load_pc. Total 10 cycles.
- Two cases:
  - JAL (1101111) → SKIP with load_pc and pcmux 0; load_regfile never asserted.
  - rst asserted in the second LD1 cycle → mem_read = 0 in that cycle; FETCH1 on the first cycle after rst releases.
